// File: rtl/overlay_sequencer.sv
// Frame-synchronous overlay sequencer: fade-in / hold / fade-out / gap brightness cycle,
// a triangle-wave vertical bounce, and a registered clamped composite of overlay over background.
module overlay_sequencer #(
    parameter int H_LAST      = 799,
    parameter int V_LAST      = 524,
    parameter int FADE_FRAMES = 4,
    parameter int HOLD_FRAMES = 120,
    parameter int GAP_FRAMES  = 30,
    parameter int BOUNCE_MAX  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       frame_active,
    input  logic       freeze,
    input  logic [5:0] background_rgb,
    input  logic [5:0] overlay_rgb_in,
    input  logic       overlay_active_in,
    output logic [9:0] x_ov,
    output logic [9:0] y_ov,
    output logic [5:0] rgb_out,
    output logic [1:0] level,
    output logic [1:0] state,
    output logic [7:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_GAP      = 2'd0,
        ST_FADE_IN  = 2'd1,
        ST_HOLD     = 2'd2,
        ST_FADE_OUT = 2'd3
    } state_t;

    localparam logic [9:0] H_LAST_V   = 10'(H_LAST);
    localparam logic [9:0] V_LAST_V   = 10'(V_LAST);
    localparam logic [7:0] FADE_LAST  = 8'(FADE_FRAMES - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_FRAMES - 1);
    localparam logic [7:0] BOUNCE_TOP = 8'(BOUNCE_MAX);

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [1:0] level_reg, level_next;
    logic [7:0] bounce_reg, bounce_next;
    logic       bounce_down_reg, bounce_down_next;
    logic [7:0] cycle_count_reg, cycle_count_next;
    logic [5:0] rgb_reg, rgb_next;
    logic [5:0] clamped_rgb;
    logic       frame_tick;
    logic       advance;

    // Everything advances only on the last pixel of a frame, so a frame sees constant settings.
    assign frame_tick = (x == H_LAST_V) && (y == V_LAST_V);
    assign advance    = frame_tick && !freeze;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_GAP;
            cnt_reg         <= 8'd0;
            level_reg       <= 2'd0;
            bounce_reg      <= 8'd0;
            bounce_down_reg <= 1'b0;
            cycle_count_reg <= 8'd0;
            rgb_reg         <= 6'd0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            level_reg       <= level_next;
            bounce_reg      <= bounce_next;
            bounce_down_reg <= bounce_down_next;
            cycle_count_reg <= cycle_count_next;
            rgb_reg         <= rgb_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        level_next       = level_reg;
        bounce_next      = bounce_reg;
        bounce_down_next = bounce_down_reg;
        cycle_count_next = cycle_count_reg;
        if (advance) begin
            if (BOUNCE_MAX == 0) begin
                bounce_next = 8'd0;
            end else if (!bounce_down_reg) begin
                if (bounce_reg == BOUNCE_TOP) begin
                    bounce_down_next = 1'b1;
                    bounce_next      = bounce_reg - 8'd1;
                end else begin
                    bounce_next = bounce_reg + 8'd1;
                end
            end else begin
                if (bounce_reg == 8'd0) begin
                    bounce_down_next = 1'b0;
                    bounce_next      = bounce_reg + 8'd1;
                end else begin
                    bounce_next = bounce_reg - 8'd1;
                end
            end

            cnt_next = cnt_reg + 8'd1;
            case (state_reg)
                ST_GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        cnt_next         = 8'd0;
                        state_next       = ST_FADE_IN;
                        level_next       = 2'd0;
                        cycle_count_next = cycle_count_reg + 8'd1;
                    end
                end
                ST_FADE_IN: begin
                    if (cnt_reg == FADE_LAST) begin
                        cnt_next   = 8'd0;
                        level_next = level_reg + 2'd1;
                        // Reaching full brightness moves straight into HOLD on the same tick.
                        if (level_reg == 2'd2) state_next = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        cnt_next   = 8'd0;
                        state_next = ST_FADE_OUT;
                    end
                end
                default: begin
                    if (cnt_reg == FADE_LAST) begin
                        cnt_next   = 8'd0;
                        level_next = level_reg - 2'd1;
                        if (level_reg == 2'd1) state_next = ST_GAP;
                    end
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_clamp
            assign clamped_rgb[2*gi+1:2*gi] =
                (overlay_rgb_in[2*gi+1:2*gi] > level_reg) ? level_reg : overlay_rgb_in[2*gi+1:2*gi];
        end
    endgenerate

    always_comb begin
        rgb_next = 6'd0;
        if (frame_active) begin
            if (overlay_active_in && (level_reg != 2'd0)) rgb_next = clamped_rgb;
            else                                          rgb_next = background_rgb;
        end
    end

    assign x_ov        = x;
    assign y_ov        = y - {2'b00, bounce_reg};
    assign rgb_out     = rgb_reg;
    assign level       = level_reg;
    assign state       = state_reg;
    assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_overlay_sequencer.sv
// Directed bench for overlay_sequencer: a per-frame vector table plus hand-written
// sequences for bounce wraparound and mid-frame reset; uses a tiny frame to keep runs short.
module tb_overlay_sequencer;

    localparam int H_LAST = 7;
    localparam int V_LAST = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] x, y;
    logic       frame_active, freeze;
    logic [5:0] background_rgb, overlay_rgb_in;
    logic       overlay_active_in;
    logic [9:0] x_ov, y_ov;
    logic [5:0] rgb_out;
    logic [1:0] level, state;
    logic [7:0] cycle_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       fz;
        logic       act;
        logic [1:0] st;
        logic [1:0] lv;
        logic [7:0] cc;
        logic [9:0] yov;
        logic [5:0] rgb;
    } vec_t;

    vec_t vecs [20];

    always #5 clk = ~clk;

    overlay_sequencer #(
        .H_LAST(H_LAST), .V_LAST(V_LAST),
        .FADE_FRAMES(2), .HOLD_FRAMES(3), .GAP_FRAMES(1), .BOUNCE_MAX(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y),
        .frame_active(frame_active), .freeze(freeze),
        .background_rgb(background_rgb), .overlay_rgb_in(overlay_rgb_in),
        .overlay_active_in(overlay_active_in),
        .x_ov(x_ov), .y_ov(y_ov), .rgb_out(rgb_out),
        .level(level), .state(state), .cycle_count(cycle_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end else begin
            $display("ok   %s value=%0d", name, act);
        end
    endtask

    task automatic run_frame(input logic fz);
        for (int yy = 0; yy <= V_LAST; yy++) begin
            for (int xx = 0; xx <= H_LAST; xx++) begin
                x            = 10'(xx);
                y            = 10'(yy);
                freeze       = fz;
                frame_active = 1'b1;
                step();
            end
        end
    endtask

    initial begin
        // Overlay 11_10_01 over background 00_10_11; expected rgb per level hand-clamped.
        vecs[0]  = '{1'b0, 1'b1, 2'd0, 2'd0, 8'd0, 10'd0,    6'b00_10_11};
        vecs[1]  = '{1'b0, 1'b1, 2'd1, 2'd0, 8'd1, 10'd1023, 6'b00_10_11};
        vecs[2]  = '{1'b0, 1'b1, 2'd1, 2'd0, 8'd1, 10'd1022, 6'b00_10_11};
        vecs[3]  = '{1'b0, 1'b1, 2'd1, 2'd1, 8'd1, 10'd1023, 6'b01_01_01};
        vecs[4]  = '{1'b0, 1'b1, 2'd1, 2'd1, 8'd1, 10'd0,    6'b01_01_01};
        vecs[5]  = '{1'b0, 1'b1, 2'd1, 2'd2, 8'd1, 10'd1023, 6'b10_10_01};
        vecs[6]  = '{1'b0, 1'b1, 2'd1, 2'd2, 8'd1, 10'd1022, 6'b10_10_01};
        vecs[7]  = '{1'b0, 1'b1, 2'd2, 2'd3, 8'd1, 10'd1023, 6'b11_10_01};
        vecs[8]  = '{1'b1, 1'b1, 2'd2, 2'd3, 8'd1, 10'd0,    6'b11_10_01};
        vecs[9]  = '{1'b1, 1'b0, 2'd2, 2'd3, 8'd1, 10'd0,    6'b00_00_00};
        vecs[10] = '{1'b1, 1'b1, 2'd2, 2'd3, 8'd1, 10'd0,    6'b11_10_01};
        vecs[11] = '{1'b0, 1'b1, 2'd2, 2'd3, 8'd1, 10'd0,    6'b11_10_01};
        vecs[12] = '{1'b0, 1'b1, 2'd2, 2'd3, 8'd1, 10'd1023, 6'b11_10_01};
        vecs[13] = '{1'b0, 1'b1, 2'd3, 2'd3, 8'd1, 10'd1022, 6'b11_10_01};
        vecs[14] = '{1'b0, 1'b1, 2'd3, 2'd3, 8'd1, 10'd1023, 6'b11_10_01};
        vecs[15] = '{1'b0, 1'b1, 2'd3, 2'd2, 8'd1, 10'd0,    6'b10_10_01};
        vecs[16] = '{1'b0, 1'b1, 2'd3, 2'd2, 8'd1, 10'd1023, 6'b10_10_01};
        vecs[17] = '{1'b0, 1'b1, 2'd3, 2'd1, 8'd1, 10'd1022, 6'b01_01_01};
        vecs[18] = '{1'b0, 1'b1, 2'd3, 2'd1, 8'd1, 10'd1023, 6'b01_01_01};
        vecs[19] = '{1'b0, 1'b1, 2'd0, 2'd0, 8'd1, 10'd0,    6'b00_10_11};

        rst_n             = 1'b0;
        x                 = 10'd0;
        y                 = 10'd0;
        frame_active      = 1'b1;
        freeze            = 1'b0;
        background_rgb    = 6'b00_10_11;
        overlay_rgb_in    = 6'b11_10_01;
        overlay_active_in = 1'b1;
        repeat (3) step();

        chk("reset_rgb", 32'(rgb_out), 32'd0);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_cycle_count", 32'(cycle_count), 32'd0);
        x = 10'd5;
        y = 10'd5;
        #1;
        chk("reset_y_ov", 32'(y_ov), 32'd5);
        chk("x_ov_passthrough", 32'(x_ov), 32'd5);
        x = 10'd0;
        y = 10'd0;
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 20; k++) begin
            x            = 10'd0;
            y            = 10'd0;
            frame_active = vecs[k].act;
            freeze       = vecs[k].fz;
            #1;
            $display("frame %0d: freeze=%0b active=%0b", k + 1, vecs[k].fz, vecs[k].act);
            chk($sformatf("f%0d_state", k + 1), 32'(state), 32'(vecs[k].st));
            chk($sformatf("f%0d_level", k + 1), 32'(level), 32'(vecs[k].lv));
            chk($sformatf("f%0d_cycle_count", k + 1), 32'(cycle_count), 32'(vecs[k].cc));
            chk($sformatf("f%0d_y_ov", k + 1), 32'(y_ov), 32'(vecs[k].yov));
            step();
            chk($sformatf("f%0d_rgb", k + 1), 32'(rgb_out), 32'(vecs[k].rgb));
            run_frame(vecs[k].fz);
        end

        // Second FADE_IN frame of the next cycle: bounce is 2, so row 1 wraps to 1023.
        run_frame(1'b0);
        x = 10'd0;
        y = 10'd1;
        #1;
        chk("bounce_wrap_y_ov", 32'(y_ov), 32'd1023);
        chk("second_cycle_state", 32'(state), 32'd1);
        chk("second_cycle_count", 32'(cycle_count), 32'd2);

        for (int n = 0; n < 20 && state != 2'd3; n++) run_frame(1'b0);
        chk("reach_fade_out", 32'(state), 32'd3);

        x                 = 10'd2;
        y                 = 10'd1;
        frame_active      = 1'b1;
        overlay_active_in = 1'b1;
        step();
        chk("pre_reset_rgb", 32'(rgb_out), 32'(6'b11_10_01));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_reset_rgb", 32'(rgb_out), 32'd0);
        chk("mid_reset_state", 32'(state), 32'd0);
        chk("mid_reset_level", 32'(level), 32'd0);
        chk("mid_reset_cycle_count", 32'(cycle_count), 32'd0);
        y = 10'd0;
        #1;
        chk("mid_reset_bounce_y_ov", 32'(y_ov), 32'd0);
        step();
        chk("post_reset_background", 32'(rgb_out), 32'(6'b00_10_11));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
